// File: rtl/mpsoc_pkg.sv
// Shared AHB3-Lite encodings and initiator FSM/boundary definitions.
package mpsoc_pkg;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [2:0] HSIZE_B8  = 3'b000;
   localparam logic [2:0] HSIZE_B16 = 3'b001;
   localparam logic [2:0] HSIZE_B32 = 3'b010;
   localparam logic [2:0] HSIZE_B64 = 3'b011;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Bursts may not cross a 1 KB address boundary without a fresh NONSEQ.
   localparam int BOUNDARY_1K_LOG2 = 10;

   typedef enum logic [1:0] {IDLE, ADDR, DATA_LAST, ERR2} fsm_state_t;
endpackage

// File: rtl/mpsoc_ahb3_addr_gen.sv
// Next beat address for an incrementing burst, plus 1 KB crossing flag.
module mpsoc_ahb3_addr_gen
   import mpsoc_pkg::*;
#(
   parameter int HADDR_SIZE = 64
)
(
   input  logic [HADDR_SIZE-1:0] addr,
   input  logic [2:0]            size,
   output logic [HADDR_SIZE-1:0] next_addr,
   output logic                  cross_1k
);
   logic [HADDR_SIZE-1:0] incr;

   assign incr      = {{(HADDR_SIZE-1){1'b0}}, 1'b1} << size;
   assign next_addr = addr + incr;
   assign cross_1k  = next_addr[HADDR_SIZE-1:BOUNDARY_1K_LOG2] != addr[HADDR_SIZE-1:BOUNDARY_1K_LOG2];
endmodule

// File: rtl/mpsoc_ahb3_initiator.sv
// AHB3-Lite burst initiator: request/write-data streams in, pipelined AHB
// address/data phases out, one response per read beat or per write burst.
module mpsoc_ahb3_initiator
   import mpsoc_pkg::*;
#(
   parameter int HADDR_SIZE = 64,
   parameter int HDATA_SIZE = 32
)
(
   input  logic                  HCLK,
   input  logic                  HRESET,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [HADDR_SIZE-1:0] req_addr,
   input  logic                  req_write,
   input  logic [2:0]            req_size,
   input  logic [3:0]            req_len,
   input  logic [3:0]            req_prot,
   input  logic                  wd_valid,
   output logic                  wd_ready,
   input  logic [HDATA_SIZE-1:0] wd_data,
   output logic                  rsp_valid,
   output logic [HDATA_SIZE-1:0] rsp_data,
   output logic                  rsp_err,
   output logic                  rsp_last,
   output logic [HADDR_SIZE-1:0] HADDR,
   output logic [HDATA_SIZE-1:0] HWDATA,
   output logic                  HWRITE,
   output logic [2:0]            HSIZE,
   output logic [2:0]            HBURST,
   output logic [3:0]            HPROT,
   output logic [1:0]            HTRANS,
   output logic                  HMASTLOCK,
   input  logic [HDATA_SIZE-1:0] HRDATA,
   input  logic                  HREADY,
   input  logic                  HRESP
);
   fsm_state_t            state;
   logic [1:0]            htrans_r;   // type the pending beat carries when issued
   logic                  first;
   logic [4:0]            beats_left; // address phases (and write words) still owed
   logic                  dph, dph_last;
   logic [HADDR_SIZE-1:0] next_addr;
   logic                  cross_1k;
   logic                  addr_acc, dph_done, err_first, drained;

   mpsoc_ahb3_addr_gen #(.HADDR_SIZE(HADDR_SIZE)) u_addr_gen (
      .addr      (HADDR),
      .size      (HSIZE),
      .next_addr (next_addr),
      .cross_1k  (cross_1k)
   );

   assign HMASTLOCK = 1'b0;
   assign addr_acc  = (state == ADDR) && (!HWRITE || wd_valid) && HREADY;
   assign dph_done  = dph && HREADY;
   assign err_first = dph && !HREADY && (HRESP == HRESP_ERROR);
   assign drained   = !HWRITE || (beats_left == 5'd0) || ((beats_left == 5'd1) && wd_valid);
   assign wd_ready  = HWRITE && (((state == ADDR) && HREADY) ||
                                 ((state == ERR2) && (beats_left != 5'd0)));

   // A write beat without data is held back: IDLE before the first beat, BUSY after.
   always_comb begin
      HTRANS = HTRANS_IDLE;
      if (state == ADDR) begin
         if (HWRITE && !wd_valid) HTRANS = first ? HTRANS_IDLE : HTRANS_BUSY;
         else                     HTRANS = htrans_r;
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state      <= IDLE;
         req_ready  <= 1'b0;
         HADDR      <= '0;
         HWDATA     <= '0;
         HWRITE     <= 1'b0;
         HSIZE      <= HSIZE_B8;
         HBURST     <= HBURST_SINGLE;
         HPROT      <= '0;
         htrans_r   <= HTRANS_IDLE;
         first      <= 1'b0;
         beats_left <= '0;
         dph        <= 1'b0;
         dph_last   <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_err    <= 1'b0;
         rsp_last   <= 1'b0;
      end else begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_last  <= 1'b0;

         if (addr_acc) begin
            dph      <= 1'b1;
            dph_last <= (beats_left == 5'd1);
         end else if (dph_done) begin
            dph <= 1'b0;
         end

         if (dph_done && (state != ERR2)) begin
            if (!HWRITE) begin
               rsp_valid <= 1'b1;
               rsp_data  <= HRDATA;
               rsp_last  <= dph_last;
            end else if (dph_last) begin
               rsp_valid <= 1'b1;
               rsp_last  <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               req_ready <= !(req_valid && req_ready);
               if (req_valid && req_ready) begin
                  HADDR      <= req_addr;
                  HWRITE     <= req_write;
                  HSIZE      <= req_size;
                  HPROT      <= req_prot;
                  HBURST     <= (req_len == 4'd0) ? HBURST_SINGLE : HBURST_INCR;
                  beats_left <= {1'b0, req_len} + 5'd1;
                  htrans_r   <= HTRANS_NONSEQ;
                  first      <= 1'b1;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               if (err_first) begin
                  state <= ERR2;
               end else if (addr_acc) begin
                  HADDR      <= next_addr;
                  htrans_r   <= cross_1k ? HTRANS_NONSEQ : HTRANS_SEQ;
                  first      <= 1'b0;
                  beats_left <= beats_left - 5'd1;
                  if (HWRITE) HWDATA <= wd_data;
                  if (beats_left == 5'd1) state <= DATA_LAST;
               end
            end
            DATA_LAST: begin
               if (err_first) begin
                  state <= ERR2;
               end else if (dph_done) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            ERR2: begin
               // Second error cycle ends the burst; leftover write words are discarded.
               if (wd_ready && wd_valid) beats_left <= beats_left - 5'd1;
               if (dph_done) begin
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b1;
                  rsp_last  <= 1'b1;
               end
               if ((!dph || HREADY) && drained) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mpsoc_ahb3_initiator.sv
// Directed bench for the AHB3-Lite initiator: bursts, waits, BUSY, 1 KB, error, reset.
module tb_mpsoc_ahb3_initiator;
   import mpsoc_pkg::*;

   localparam int AW = 64;
   localparam int DW = 32;

   logic          HCLK = 1'b0;
   logic          HRESET = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic          req_write = 1'b0;
   logic [2:0]    req_size = '0;
   logic [3:0]    req_len = '0;
   logic [3:0]    req_prot = '0;
   logic          wd_valid = 1'b0;
   logic          wd_ready;
   logic [DW-1:0] wd_data = '0;
   logic          rsp_valid, rsp_err, rsp_last;
   logic [DW-1:0] rsp_data;
   logic [AW-1:0] HADDR;
   logic [DW-1:0] HWDATA;
   logic          HWRITE, HMASTLOCK;
   logic [2:0]    HSIZE, HBURST;
   logic [3:0]    HPROT;
   logic [1:0]    HTRANS;
   logic [DW-1:0] HRDATA = '0;
   logic          HREADY = 1'b1;
   logic          HRESP = 1'b0;

   int n_chk = 0;
   int n_fail = 0;

   logic [DW-1:0] r_data [64];
   logic          r_err  [64];
   logic          r_last [64];
   int            rsp_n = 0;

   mpsoc_ahb3_initiator #(.HADDR_SIZE(AW), .HDATA_SIZE(DW)) dut (
      .HCLK(HCLK), .HRESET(HRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_size(req_size), .req_len(req_len), .req_prot(req_prot),
      .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_last(rsp_last),
      .HADDR(HADDR), .HWDATA(HWDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
      .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) begin
      if (rsp_valid === 1'b1) begin
         if (rsp_n < 64) begin
            r_data[rsp_n] = rsp_data;
            r_err[rsp_n]  = rsp_err;
            r_last[rsp_n] = rsp_last;
         end
         rsp_n++;
      end
   end

   task automatic next_cyc;
      @(posedge HCLK);
      #1;
   endtask

   // Presents a request for one cycle; caller must know req_ready is high.
   task automatic start_req(input logic [AW-1:0] a, input logic w, input logic [2:0] sz,
                            input logic [3:0] len, input logic [3:0] prot);
      req_valid = 1'b1; req_addr = a; req_write = w;
      req_size = sz; req_len = len; req_prot = prot;
      next_cyc;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge HCLK);
      n_chk++;
      if ({HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, req_ready,
           wd_ready, rsp_valid, rsp_err, rsp_last, rsp_data} !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got nonzero HTRANS=%0d HADDR=%h req_ready=%b want all 0",
                            HTRANS, HADDR, req_ready);
      end
      next_cyc;
      HRESET = 1'b0;
      @(negedge HCLK);
      n_chk++;
      if (req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rdy_early: got %b want 0", req_ready); end
      next_cyc;
      n_chk++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_rdy_rise: got %b want 1", req_ready); end
   endtask

   task automatic test_read_burst;
      int base;
      logic [1:0] exp_tr;
      base = rsp_n;
      HREADY = 1'b1; HRESP = 1'b0;
      start_req(64'h100, 1'b0, HSIZE_B32, 4'd3, 4'h3);
      for (int k = 0; k < 5; k++) begin
         HRDATA = 32'hD000_0000 + k;
         @(negedge HCLK);
         exp_tr = (k == 4) ? HTRANS_IDLE : ((k == 0) ? HTRANS_NONSEQ : HTRANS_SEQ);
         n_chk++;
         if (HTRANS !== exp_tr) begin
            n_fail++; $display("FAIL rd_htrans[%0d]: got %0d want %0d", k, HTRANS, exp_tr);
         end
         if (k < 4) begin
            n_chk++;
            if (HADDR !== 64'h100 + 64'(4 * k)) begin
               n_fail++; $display("FAIL rd_haddr[%0d]: got %h want %h", k, HADDR, 64'h100 + 64'(4 * k));
            end
         end
         if (k == 0) begin
            n_chk++;
            if ({HBURST, HSIZE, HPROT, HWRITE, HMASTLOCK} !== {HBURST_INCR, HSIZE_B32, 4'h3, 1'b0, 1'b0}) begin
               n_fail++; $display("FAIL rd_ctrl: got burst=%0d size=%0d prot=%h want 1 2 3", HBURST, HSIZE, HPROT);
            end
         end
         next_cyc;
      end
      @(negedge HCLK);
      n_chk++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rd_req_ready: got %b want 1", req_ready); end
      next_cyc;
      n_chk++;
      if (rsp_n - base !== 4) begin n_fail++; $display("FAIL rd_rsp_count: got %0d want 4", rsp_n - base); end
      else for (int j = 0; j < 4; j++) begin
         n_chk++;
         if ({r_data[base+j], r_last[base+j], r_err[base+j]} !== {32'hD000_0001 + 32'(j), (j == 3), 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp[%0d]: got data=%h last=%b err=%b want %h %b 0",
                               j, r_data[base+j], r_last[base+j], r_err[base+j], 32'hD000_0001 + 32'(j), (j == 3));
         end
      end
   endtask

   task automatic test_write_wait;
      int base;
      logic          rdy_v [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic          wdv_v [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [DW-1:0] wdd_v [5] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h0, 32'h0};
      logic [DW-1:0] hwd_v [5] = '{32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h5A5A5A5A};
      logic [1:0]    tr_v  [5] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE};
      base = rsp_n;
      start_req(64'h200, 1'b1, HSIZE_B32, 4'd1, 4'h1);
      for (int k = 0; k < 5; k++) begin
         HREADY = rdy_v[k]; wd_valid = wdv_v[k]; wd_data = wdd_v[k];
         @(negedge HCLK);
         n_chk++;
         if (HTRANS !== tr_v[k] || wd_ready !== (k == 0 || k == 2)) begin
            n_fail++; $display("FAIL wr_phase[%0d]: got htrans=%0d wd_ready=%b want %0d %b",
                               k, HTRANS, wd_ready, tr_v[k], (k == 0 || k == 2));
         end
         if (k > 0) begin
            n_chk++;
            if (HWDATA !== hwd_v[k]) begin
               n_fail++; $display("FAIL wr_hwdata[%0d]: got %h want %h", k, HWDATA, hwd_v[k]);
            end
         end
         next_cyc;
      end
      HREADY = 1'b1;
      next_cyc;
      n_chk++;
      if (rsp_n - base !== 1 || r_err[base] !== 1'b0 || r_last[base] !== 1'b1) begin
         n_fail++; $display("FAIL wr_rsp: got count=%0d err=%b last=%b want 1 0 1", rsp_n - base, r_err[base], r_last[base]);
      end
   endtask

   task automatic test_busy;
      int base;
      logic [DW-1:0] hwd_exp;
      logic       wdv_v [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [1:0] tr_v  [8] = '{HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY,
                                HTRANS_BUSY, HTRANS_BUSY, HTRANS_SEQ, HTRANS_IDLE};
      base = rsp_n;
      HREADY = 1'b1;
      start_req(64'h300, 1'b1, HSIZE_B32, 4'd2, 4'h0);
      for (int k = 0; k < 8; k++) begin
         wd_valid = wdv_v[k]; wd_data = 32'hC0DE_0000 + k;
         @(negedge HCLK);
         n_chk++;
         if (HTRANS !== tr_v[k]) begin
            n_fail++; $display("FAIL busy_htrans[%0d]: got %0d want %0d", k, HTRANS, tr_v[k]);
         end
         if (k == 6) begin
            n_chk++;
            if (HADDR !== 64'h308) begin n_fail++; $display("FAIL busy_haddr: got %h want 308", HADDR); end
         end
         if (k == 4) begin
            hwd_exp = 32'hC0DE_0002;
            n_chk++;
            if (HWDATA !== hwd_exp) begin n_fail++; $display("FAIL busy_hwdata: got %h want %h", HWDATA, hwd_exp); end
         end
         next_cyc;
      end
      wd_valid = 1'b0;
      next_cyc;
      n_chk++;
      if (rsp_n - base !== 1) begin n_fail++; $display("FAIL busy_rsp_count: got %0d want 1", rsp_n - base); end
   endtask

   task automatic test_boundary;
      int base;
      base = rsp_n;
      HREADY = 1'b1; HRESP = 1'b0;
      start_req(64'h3FC, 1'b0, HSIZE_B32, 4'd1, 4'h0);
      next_cyc;
      @(negedge HCLK);
      n_chk++;
      if (HTRANS !== HTRANS_NONSEQ || HADDR !== 64'h400) begin
         n_fail++; $display("FAIL bnd_beat2: got htrans=%0d haddr=%h want 2 400", HTRANS, HADDR);
      end
      next_cyc; next_cyc; next_cyc;
      // single-beat read uses SINGLE and closes on its only beat
      start_req(64'h40, 1'b0, HSIZE_B16, 4'd0, 4'h0);
      @(negedge HCLK);
      n_chk++;
      if (HBURST !== HBURST_SINGLE || HTRANS !== HTRANS_NONSEQ) begin
         n_fail++; $display("FAIL single_burst: got hburst=%0d htrans=%0d want 0 2", HBURST, HTRANS);
      end
      next_cyc; next_cyc; next_cyc;
      n_chk++;
      if (rsp_n - base !== 3 || r_last[base+2] !== 1'b1 || r_last[base] !== 1'b0) begin
         n_fail++; $display("FAIL bnd_rsp: got count=%0d want 3", rsp_n - base);
      end
   endtask

   task automatic test_error;
      int base;
      logic       rdy_v [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic       rsp_v [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [1:0] tr_v  [6] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_SEQ, HTRANS_IDLE, HTRANS_IDLE, HTRANS_IDLE};
      base = rsp_n;
      start_req(64'h500, 1'b0, HSIZE_B32, 4'd3, 4'h0);
      for (int k = 0; k < 6; k++) begin
         HREADY = rdy_v[k]; HRESP = rsp_v[k]; HRDATA = 32'h11 + k - 1;
         @(negedge HCLK);
         n_chk++;
         if (HTRANS !== tr_v[k]) begin
            n_fail++; $display("FAIL err_htrans[%0d]: got %0d want %0d", k, HTRANS, tr_v[k]);
         end
         if (k == 4) begin
            n_chk++;
            if (req_ready !== 1'b1) begin n_fail++; $display("FAIL err_req_ready: got %b want 1", req_ready); end
         end
         next_cyc;
      end
      HRESP = 1'b0;
      n_chk++;
      if (rsp_n - base !== 2) begin n_fail++; $display("FAIL err_rsp_count: got %0d want 2", rsp_n - base); end
      else begin
         n_chk++;
         if ({r_data[base], r_err[base], r_last[base], r_err[base+1], r_last[base+1]} !==
             {32'h11, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL err_rsp: got data=%h e0=%b l0=%b e1=%b l1=%b want 11 0 0 1 1",
                               r_data[base], r_err[base], r_last[base], r_err[base+1], r_last[base+1]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int base;
      base = rsp_n;
      HREADY = 1'b1; wd_valid = 1'b1; wd_data = 32'h600D_F00D;
      start_req(64'h600, 1'b1, HSIZE_B32, 4'd7, 4'h5);
      next_cyc; next_cyc;
      HRESET = 1'b1;
      #1;
      n_chk++;
      if ({HTRANS, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, req_ready,
           wd_ready, rsp_valid, rsp_err, rsp_last, rsp_data} !== '0) begin
         n_fail++; $display("FAIL rstmid_outputs: got HTRANS=%0d HADDR=%h HWDATA=%h wd_ready=%b want all 0",
                            HTRANS, HADDR, HWDATA, wd_ready);
      end
      wd_valid = 1'b0;
      next_cyc; next_cyc;
      HRESET = 1'b0;
      next_cyc;
      n_chk++;
      if (req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
      next_cyc;
      n_chk++;
      if (rsp_n !== base) begin n_fail++; $display("FAIL rstmid_no_rsp: got %0d rsp want 0", rsp_n - base); end
   endtask

   initial begin
      test_reset;
      test_read_burst;
      next_cyc;
      test_write_wait;
      next_cyc;
      test_busy;
      next_cyc;
      test_boundary;
      next_cyc;
      test_error;
      next_cyc;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
